// File: rtl/morse_char_dec_if.sv
// morse_char_dec_if: decoded character stream toward the display/UART stage (valid/ready)
interface morse_char_dec_if;
    logic [7:0] char;
    logic       char_valid;
    logic       char_ready;
    logic       err;
    modport master(output char, char_valid, err, input char_ready);
    modport slave(input char, char_valid, err, output char_ready);
endinterface

// File: rtl/morse_char_dec.sv
// morse_char_dec: classifies recorded mark durations as dot/dash and emits one ASCII char per record
// Optional adaptive dot/dash threshold (SCAN state): define MORSE_DEC_ADAPTIVE_EN
module morse_char_dec #(
    parameter int WID      = 32,
    parameter int DASH_MIN = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               m_end,
    input  logic [2:0]         sym_ct,
    input  logic [5*WID-1:0]   value,
    output logic               busy,
    morse_char_dec_if.master   bus
);
`ifdef MORSE_DEC_ADAPTIVE_EN
    typedef enum logic [2:0] {IDLE, SCAN, CLASSIFY, LOOKUP, OUTPUT} state_t;
    localparam state_t FIRST = SCAN;
`else
    typedef enum logic [2:0] {IDLE, CLASSIFY, LOOKUP, OUTPUT} state_t;
    localparam state_t FIRST = CLASSIFY;
`endif
    state_t           state, state_nx;
    logic             m_end_q, rise, bad_ct, last, sticky, err_q, valid_q;
    logic [5*WID-1:0] val_q;
    logic [2:0]       ct_q, idx;
    logic [4:0]       pattern;
    logic [WID-1:0]   dur, thr;
    logic [7:0]       code, char_q;
`ifdef MORSE_DEC_ADAPTIVE_EN
    logic [WID-1:0]   mn, mx;
    logic [WID:0]     sum;
`endif

    // Morse table keyed by {length, pattern}; bit0 is the first mark, dash = 1; 0 means no match
    function automatic logic [7:0] morse(input logic [2:0] n, input logic [4:0] p);
        case ({n, p})
            {3'd1, 5'd0}:  morse = "E";
            {3'd1, 5'd1}:  morse = "T";
            {3'd2, 5'd0}:  morse = "I";
            {3'd2, 5'd2}:  morse = "A";
            {3'd2, 5'd1}:  morse = "N";
            {3'd2, 5'd3}:  morse = "M";
            {3'd3, 5'd0}:  morse = "S";
            {3'd3, 5'd4}:  morse = "U";
            {3'd3, 5'd2}:  morse = "R";
            {3'd3, 5'd6}:  morse = "W";
            {3'd3, 5'd1}:  morse = "D";
            {3'd3, 5'd5}:  morse = "K";
            {3'd3, 5'd3}:  morse = "G";
            {3'd3, 5'd7}:  morse = "O";
            {3'd4, 5'd0}:  morse = "H";
            {3'd4, 5'd8}:  morse = "V";
            {3'd4, 5'd4}:  morse = "F";
            {3'd4, 5'd2}:  morse = "L";
            {3'd4, 5'd6}:  morse = "P";
            {3'd4, 5'd14}: morse = "J";
            {3'd4, 5'd1}:  morse = "B";
            {3'd4, 5'd9}:  morse = "X";
            {3'd4, 5'd5}:  morse = "C";
            {3'd4, 5'd13}: morse = "Y";
            {3'd4, 5'd3}:  morse = "Z";
            {3'd4, 5'd11}: morse = "Q";
            {3'd5, 5'd31}: morse = "0";
            {3'd5, 5'd30}: morse = "1";
            {3'd5, 5'd28}: morse = "2";
            {3'd5, 5'd24}: morse = "3";
            {3'd5, 5'd16}: morse = "4";
            {3'd5, 5'd0}:  morse = "5";
            {3'd5, 5'd1}:  morse = "6";
            {3'd5, 5'd3}:  morse = "7";
            {3'd5, 5'd7}:  morse = "8";
            {3'd5, 5'd15}: morse = "9";
            default:       morse = 8'h00;
        endcase
    endfunction

    // Edge detect, current mark selection, threshold and table lookup
    always_comb begin
        rise   = m_end & ~m_end_q;
        bad_ct = sym_ct == 3'd0 || sym_ct > 3'd5;
        last   = idx == ct_q - 3'd1;
        dur    = val_q[idx*WID +: WID];
        code   = morse(ct_q, pattern);
`ifdef MORSE_DEC_ADAPTIVE_EN
        sum    = {1'b0, mn} + {1'b0, mx};
        thr    = ({1'b0, mx} >= {mn, 1'b0}) ? sum[WID:1] : WID'(DASH_MIN);
`else
        thr    = WID'(DASH_MIN);
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; m_end edges outside IDLE are simply never looked at
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (rise) state_nx = bad_ct ? LOOKUP : FIRST;
`ifdef MORSE_DEC_ADAPTIVE_EN
            SCAN:     if (last) state_nx = CLASSIFY;
`endif
            CLASSIFY: if (last) state_nx = LOOKUP;
            LOOKUP:   state_nx = OUTPUT;
            OUTPUT:   if (valid_q && bus.char_ready) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Record capture, min/max scan, per-mark classification and registered result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_end_q <= 1'b1;
            val_q   <= '0;
            ct_q    <= '0;
            idx     <= '0;
            pattern <= '0;
            sticky  <= 1'b0;
            char_q  <= 8'h00;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef MORSE_DEC_ADAPTIVE_EN
            mn      <= '0;
            mx      <= '0;
`endif
        end else begin
            m_end_q <= m_end;
            case (state)
                IDLE: if (rise) begin
                    val_q   <= value;
                    ct_q    <= sym_ct;
                    idx     <= '0;
                    pattern <= '0;
                    sticky  <= bad_ct;
`ifdef MORSE_DEC_ADAPTIVE_EN
                    mn      <= '1;
                    mx      <= '0;
`endif
                end
`ifdef MORSE_DEC_ADAPTIVE_EN
                SCAN: begin
                    if (dur != '0 && dur < mn) mn <= dur;
                    if (dur > mx) mx <= dur;
                    idx <= last ? 3'd0 : idx + 3'd1;
                end
`endif
                CLASSIFY: begin
                    pattern[idx] <= dur >= thr;
                    if (dur == '0) sticky <= 1'b1;
                    idx <= idx + 3'd1;
                end
                LOOKUP: begin
                    char_q  <= (sticky || code == 8'h00) ? 8'h3F : code;
                    err_q   <= sticky || code == 8'h00;
                    valid_q <= 1'b1;
                end
                OUTPUT: if (bus.char_ready) valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy           = state != IDLE;
        bus.char       = char_q;
        bus.char_valid = valid_q;
        bus.err        = err_q;
    end
endmodule

// File: doc/morse_char_dec.md
# morse_char_dec

Consumes the mark-duration record produced by the Morse recorder stage (up to five high-pulse durations in clock cycles, plus a count and an end-of-character flag). Classifies each mark as dot or dash, looks up the resulting code, and emits one ASCII character per recorded character. The output uses a valid/ready handshake toward the display/UART stage.

## Interface
- WID, 32, width of each duration field in clock cycles
- DASH_MIN, 16, fixed threshold: duration >= DASH_MIN is a dash

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- m_end  in  1  recorder end-of-character level; a rising edge requests decode
- sym_ct  in  3  number of valid marks in value, 0..5
- value  in  5*WID  durations; mark i at [i*WID +: WID], mark 0 received first
- char  out  8  ASCII result
- char_valid  out  1  char is valid; held until accepted
- char_ready  in  1  consumer accepts char when high with char_valid
- err  out  1  qualifies char; 1 = invalid record, char is '?' (0x3F)
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, SCAN (present only with the macro), CLASSIFY, LOOKUP, OUTPUT.
- m_end_q register; edge = m_end & ~m_end_q. Recorder fields are sampled only on that edge.
- IDLE: on edge, latch value and sym_ct into shadow registers, clear pattern and idx, and go to SCAN or CLASSIFY. If sym_ct is 0 or >5, go directly to LOOKUP with a forced error.
- CLASSIFY: one mark per cycle, idx 0..sym_ct-1.
  - pattern[idx] = (dur >= thr), with dash = 1.
  - dur == 0 sets a sticky error.
  - After the last mark, go to LOOKUP.
- LOOKUP: one cycle. Map {sym_ct, pattern[4:0]} through the standard table: A–Z to 0x41–0x5A, 0–9 to 0x30–0x39.
  - Example: 'A' is len 2, pattern bit0 = 0, bit1 = 1.
  - No match or sticky error gives char = 0x3F, err = 1.
  - Register char/err, set char_valid, go to OUTPUT.
- OUTPUT: char, err and char_valid stay stable until char_valid & char_ready. Then clear char_valid and return to IDLE.
- An m_end edge in any state other than IDLE is dropped. There is no queue.
- Pattern bits at or above sym_ct are zero.

## Timing
- Reset values:
  - char = 0x00, char_valid = 0, err = 0, busy = 0, state = IDLE.
  - Shadow regs, pattern and idx = 0.
  - m_end_q = 1, so an m_end still high after reset release is not an edge.
- Reset asserted mid-decode aborts immediately. Any pending char is discarded.
- Capture edge E0. CLASSIFY occupies E1..Ek (k = sym_ct). LOOKUP registers the output at E(k+1), so char_valid is high after E(k+1).
  - Example: for k = 2, char_valid is high 3 cycles after E0.
- With the macro, SCAN adds k cycles, so char_valid is high after E(2k+1).
- Forced-error path: char_valid is high after E1.
- Handshake completes on the edge where char_valid & char_ready. The earliest next capture is the following edge.
- Throughput limit: at most one character per k+3 cycles (2k+3 with the macro).

## Configuration
- MORSE_DEC_ADAPTIVE_EN defined:
  - SCAN tracks min/max over the k durations.
  - If max >= 2*min: thr = (min+max)>>1, using a (WID+1)-bit sum.
  - Otherwise all marks are the same kind, and thr = DASH_MIN.
  - Zero durations are excluded from min.
- Undefined: no SCAN state; thr = DASH_MIN always.

## Test plan
- sym_ct=2, value={18,13}, m_end rises, char_ready=1 -> char=0x41 'A', err=0, char_valid high 3 cycles after capture (5 with macro), one cycle wide.
- sym_ct=3, durations 12,12,12 -> 0x53 'S'. sym_ct=5, all durations 20 -> 0x30 '0'. Both results are the same with and without the macro.
- 'A' record, char_ready held low 10 cycles, second m_end edge during OUTPUT -> char/char_valid stable for all 10 cycles; exactly one char accepted; second edge ignored; busy returns 0.
- Invalid inputs, each -> char=0x3F, err=1:
  - sym_ct=4, pattern ..-- ;
  - sym_ct=0 (char_valid after 1 cycle);
  - sym_ct=2 with a zero duration.
- reset low during CLASSIFY while m_end stays high -> all outputs 0, IDLE; no capture after release until m_end goes low then high.
- Durations 30,90 -> 0x41 'A' with MORSE_DEC_ADAPTIVE_EN (thr=60), 0x4D 'M' without (both >= 16).
